// File: rtl/booth_iter_mul_pkg.sv
// Shared types and sizing helpers for the iterative radix-4 Booth multiplier.
// Provides the FSM state enum, the Booth digit enum and the digit-count function.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    NEG1,
    POS2,
    NEG2
  } booth_digit_t;

  // Operands are widened by two bits so the unsigned case stays positive under signed recoding.
  function automatic int boothDigits(input int width);
    return (width + 2) / 2;
  endfunction

endpackage

// File: rtl/booth_iter_mul_pp_gen.sv
// Combinational radix-4 Booth partial-product cell (booth_pp_gen), parametrised by extended width E.
// Negative digits return the inverted pattern; the caller injects o_neg at the digit's weight.
module booth_pp_gen
  import mul_pkg::*;
#(
  parameter int E = 34
) (
  input  logic [2:0]   i_window,
  input  logic [E-1:0] i_mcand,
  output logic [E:0]   o_pp,
  output logic         o_neg
);

  booth_digit_t w_digit;
  logic [E:0]   w_x1;
  logic [E:0]   w_x2;

  assign w_x1 = {i_mcand[E-1], i_mcand};
  assign w_x2 = {i_mcand, 1'b0};

  always_comb begin
    case (i_window)
      3'b001, 3'b010: w_digit = POS1;
      3'b011:         w_digit = POS2;
      3'b100:         w_digit = NEG2;
      3'b101, 3'b110: w_digit = NEG1;
      default:        w_digit = ZERO;
    endcase
  end

  always_comb begin
    o_pp  = '0;
    o_neg = 1'b0;
    case (w_digit)
      POS1: o_pp = w_x1;
      POS2: o_pp = w_x2;
      NEG1: begin
        o_pp  = ~w_x1;
        o_neg = 1'b1;
      end
      NEG2: begin
        o_pp  = ~w_x2;
        o_neg = 1'b1;
      end
      default: o_pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_iter_mul.sv
// Iterative radix-4 Booth multiplier: one digit per cycle into a 2*(WIDTH+2)-bit accumulator.
// Optional macro BOOTH_EARLY_TERM_EN ends BUSY as soon as all remaining Booth digits are zero.
module booth_iter_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mul_signed,
  input  logic [WIDTH-1:0]     src_a,
  input  logic [WIDTH-1:0]     src_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int E  = WIDTH + 2;
  localparam int N  = boothDigits(WIDTH);
  localparam int AW = 2 * E;
  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] LAST_K = KW'(N - 1);

  state_t          r_state;
  logic [E-1:0]    r_mcand;
  logic [E-1:0]    r_mult;
  logic [AW-1:0]   r_acc;
  logic [KW-1:0]   r_k;
  logic            r_outValid;

  logic            w_accept;
  logic [E-1:0]    w_aExt;
  logic [E-1:0]    w_bExt;
  logic [E:0]      w_multExt;
  logic [2:0]      w_window;
  logic [E:0]      w_pp;
  logic            w_neg;
  logic [KW:0]     w_shamt;
  logic [AW-1:0]   w_ppExt;
  logic [AW-1:0]   w_negExt;
  logic [AW-1:0]   w_accNext;
  logic            w_finish;

  assign in_ready  = ~flush & ((r_state == IDLE) | ((r_state == DONE) & out_ready));
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_outValid;
  assign product   = r_acc[2*WIDTH-1:0];

  assign w_aExt = mul_signed ? {{2{src_a[WIDTH-1]}}, src_a} : {2'b00, src_a};
  assign w_bExt = mul_signed ? {{2{src_b[WIDTH-1]}}, src_b} : {2'b00, src_b};

  // Bit 0 of w_multExt is the implicit y[-1]; digit k reads w_multExt[2k+2:2k].
  assign w_multExt = {r_mult, 1'b0};

  always_comb begin
    w_window = '0;
    for (int j = 0; j < N; j++) begin
      if (r_k == KW'(j)) begin
        w_window = w_multExt[2*j+2 -: 3];
      end
    end
  end

  booth_pp_gen #(
    .E(E)
  ) u_ppGen (
    .i_window (w_window),
    .i_mcand  (r_mcand),
    .o_pp     (w_pp),
    .o_neg    (w_neg)
  );

  assign w_shamt   = {r_k, 1'b0};
  assign w_ppExt   = {{(AW-E-1){w_pp[E]}}, w_pp};
  assign w_negExt  = {{(AW-1){1'b0}}, w_neg};
  assign w_accNext = r_acc + (w_ppExt << w_shamt) + (w_negExt << w_shamt);

`ifdef BOOTH_EARLY_TERM_EN
  // Arithmetic shift by 2k+1 leaves all-sign bits exactly when the untouched upper multiplier bits agree.
  logic [KW:0]  w_upShamt;
  logic [E-1:0] w_rest;

  assign w_upShamt = {r_k, 1'b1};
  assign w_rest    = $signed(r_mult) >>> w_upShamt;
  assign w_finish  = (r_k == LAST_K) | (w_rest == '0) | (&w_rest);
`else
  assign w_finish  = (r_k == LAST_K);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_mcand    <= '0;
      r_mult     <= '0;
      r_acc      <= '0;
      r_k        <= '0;
      r_outValid <= 1'b0;
    end else if (flush) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        BUSY: begin
          r_acc <= w_accNext;
          r_k   <= r_k + 1'b1;
          if (w_finish) begin
            r_state    <= DONE;
            r_outValid <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE share the accept path so a DONE handoff restarts with no bubble.
          if (w_accept) begin
            r_mcand    <= w_aExt;
            r_mult     <= w_bExt;
            r_acc      <= '0;
            r_k        <= '0;
            r_state    <= BUSY;
            r_outValid <= 1'b0;
          end else if ((r_state == DONE) && out_ready) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_iter_mul.sv
// Self-checking bench for booth_iter_mul: directed plan cases, handshake/flush/reset cases,
// and randomized operands checked against an arithmetic reference product and latency rule.
module tb_booth_iter_mul;

  localparam int WIDTH = 32;
  localparam int E     = WIDTH + 2;
  localparam int N     = E / 2;
`ifdef BOOTH_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              mul_signed;
  logic [WIDTH-1:0]  src_a;
  logic [WIDTH-1:0]  src_b;
  logic              out_valid;
  logic              out_ready;
  logic [2*WIDTH-1:0] product;

  int checks = 0;
  int errors = 0;

  booth_iter_mul #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mul_signed (mul_signed),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, actual, expected);
    end
  endtask

  // Reference product: extend both operands to 64 bits per mode and multiply.
  function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b, input bit s);
    logic [63:0] xa;
    logic [63:0] xb;
    xa = s ? {{32{a[31]}}, a} : {32'b0, a};
    xb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return xa * xb;
  endfunction

  // Reference latency (accept cycle to first out_valid cycle).
  function automatic int refLatency(input logic [31:0] b, input bit s);
    logic [E-1:0] y;
    bit same;
    y = s ? {{2{b[31]}}, b} : {2'b00, b};
    if (EARLY) begin
      for (int k = 0; k < N; k++) begin
        same = 1'b1;
        for (int j = 2*k + 1; j < E; j++) begin
          if (y[j] != y[E-1]) same = 1'b0;
        end
        if (same) return k + 2;
      end
    end
    return N + 1;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 4))
      0: return $urandom();
      1: return 32'($urandom_range(0, 1023));
      2: return 32'h0 - 32'($urandom_range(1, 1023));
      3: begin
        case ($urandom_range(0, 4))
          0: return 32'h0000_0000;
          1: return 32'h0000_0001;
          2: return 32'hFFFF_FFFF;
          3: return 32'h8000_0000;
          default: return 32'h7FFF_FFFF;
        endcase
      end
      default: return 32'(1) << $urandom_range(0, 31);
    endcase
  endfunction

  // Presents one operation for a single edge; returns #1 after the accept edge (cycle 1).
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit s);
    src_a      = a;
    src_b      = b;
    mul_signed = s;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
  endtask

  task automatic waitResult(input string tag, input logic [63:0] expP, input int expLat);
    int cyc;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput({tag, "_latency"}, 64'(cyc), 64'(expLat));
    checkOutput({tag, "_product"}, product, expP);
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input bit s, input logic [63:0] expP);
    out_ready = 1'b1;
    applyStimulus(a, b, s);
    waitResult(tag, expP, refLatency(b, s));
    @(posedge clk);
    #1;
    checkOutput({tag, "_retired"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rs;
    logic [63:0] expHeld;
    bit          seen;

    reset      = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    mul_signed = 1'b0;
    src_a      = '0;
    src_b      = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_product", product, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    runOp("neg3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    runOp("umax_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    runOp("sneg1_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    runOp("smin_sq", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    runOp("umsb_sq", 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
    runOp("b_zero", 32'h1234_5678, 32'd0, 1'b0, 64'd0);
    runOp("b_one", 32'h1234_5678, 32'd1, 1'b1, 64'h0000_0000_1234_5678);
    runOp("b_0x100", 32'd3, 32'h100, 1'b0, 64'h300);

    // Backpressure then back-to-back handoff.
    out_ready = 1'b0;
    applyStimulus(32'd123456789, 32'hFFFF_0001, 1'b1);
    expHeld = refProduct(32'd123456789, 32'hFFFF_0001, 1'b1);
    waitResult("bp", expHeld, refLatency(32'hFFFF_0001, 1'b1));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_hold_product", product, expHeld);
      checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    src_a      = 32'hDEAD_BEEF;
    src_b      = 32'h0000_BEEF;
    mul_signed = 1'b0;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    #1;
    checkOutput("handoff_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("handoff_old_retired", 64'(out_valid), 64'd0);
    waitResult("b2b", refProduct(32'hDEAD_BEEF, 32'h0000_BEEF, 1'b0), refLatency(32'h0000_BEEF, 1'b0));
    @(posedge clk);
    #1;

    // Flush in BUSY cycle 7.
    applyStimulus(32'h0BAD_F00D, 32'h7654_3210, 1'b0);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    #1;
    checkOutput("flush_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    checkOutput("flush_in_ready_next", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("flush_no_valid", 64'(seen), 64'd0);
    runOp("after_flush_7x6", 32'd7, 32'd6, 1'b0, 64'd42);

    // Flush in DONE while out_ready and in_valid are high: result dropped, nothing accepted.
    out_ready = 1'b0;
    applyStimulus(32'd99, 32'd77, 1'b0);
    waitResult("done_flush_pre", 64'd7623, refLatency(32'd77, 1'b0));
    out_ready = 1'b1;
    in_valid  = 1'b1;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("done_flush_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("done_flush_no_accept", 64'(seen), 64'd0);

    // Reset mid-BUSY.
    applyStimulus(32'h1357_9BDF, 32'h2468_ACE0, 1'b1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("midreset_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_product", product, 64'd0);
    checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
    runOp("after_reset", 32'hFFFF_FFF0, 32'd16, 1'b1, 64'hFFFF_FFFF_FFFF_FF00);

    for (int i = 0; i < 60; i++) begin
      ra = pickOperand();
      rb = pickOperand();
      rs = 1'($urandom_range(0, 1));
      runOp("rand", ra, rb, rs, refProduct(ra, rb, rs));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
